// File: rtl/input_config_loader.sv
// Byte-stream loader for the per-game input mapping: 35 bytes are assembled in a
// shadow buffer and copied to the live configuration fields in one atomic commit.
module input_config_loader #(
  parameter logic [7:0] UNUSED_CODE = 8'h7F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        load_end,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        config_valid,
  output logic        commit_pulse,
  output logic        load_error,
  output logic [31:0] input_s0_config,
  output logic [31:0] input_s1_config,
  output logic [31:0] input_s2_config,
  output logic [31:0] input_s3_config,
  output logic [31:0] input_s4_config,
  output logic [31:0] input_s5_config,
  output logic [31:0] input_s6_config,
  output logic [31:0] input_s7_config,
  output logic [7:0]  input_b_config,
  output logic [7:0]  input_ba_config,
  output logic [7:0]  input_acl_config
);

  localparam int CONFIG_BYTES = 35;
  localparam logic [5:0] LAST_IDX = 6'(CONFIG_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_e;

  // Handshake: a byte transfers on a rising edge where data_valid && data_ready;
  // data_ready is high exactly while in S_LOAD and does not depend on data_valid.

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  shadow_q [CONFIG_BYTES];
  logic [7:0]  shadow_d [CONFIG_BYTES];
  logic [7:0]  live_q   [CONFIG_BYTES];
  logic [7:0]  live_d   [CONFIG_BYTES];
  logic        config_valid_q, config_valid_d;
  logic        commit_pulse_q, commit_pulse_d;
  logic        load_error_q, load_error_d;
  logic        accept;

  assign accept = data_valid && (state_q == S_LOAD);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    live_d         = live_q;
    config_valid_d = config_valid_q;
    load_error_d   = load_error_q;
    commit_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d      = S_LOAD;
          cnt_d        = 6'd0;
          load_error_d = 1'b0;
        end
      end
      S_LOAD: begin
        // A restart drops any byte offered on the same edge and outranks load_end.
        if (load_start) begin
          cnt_d        = 6'd0;
          load_error_d = 1'b0;
        end else begin
          if (accept) begin
            shadow_d[cnt_q] = data_in;
            cnt_d           = cnt_q + 6'd1;
          end
          if (accept && (cnt_q == LAST_IDX)) begin
            state_d = S_COMMIT;
          end else if (load_end) begin
            load_error_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        live_d         = shadow_q;
        config_valid_d = 1'b1;
        commit_pulse_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 6'd0;
      config_valid_q <= 1'b0;
      commit_pulse_q <= 1'b0;
      load_error_q   <= 1'b0;
      for (int i = 0; i < CONFIG_BYTES; i++) begin
        shadow_q[i] <= UNUSED_CODE;
        live_q[i]   <= UNUSED_CODE;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      config_valid_q <= config_valid_d;
      commit_pulse_q <= commit_pulse_d;
      load_error_q   <= load_error_d;
      for (int i = 0; i < CONFIG_BYTES; i++) begin
        shadow_q[i] <= shadow_d[i];
        live_q[i]   <= live_d[i];
      end
    end
  end

  assign data_ready   = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign config_valid = config_valid_q;
  assign commit_pulse = commit_pulse_q;
  assign load_error   = load_error_q;

  // Little-endian packing: stream byte 4k lands in bits [7:0] of word k.
  assign input_s0_config  = {live_q[3],  live_q[2],  live_q[1],  live_q[0]};
  assign input_s1_config  = {live_q[7],  live_q[6],  live_q[5],  live_q[4]};
  assign input_s2_config  = {live_q[11], live_q[10], live_q[9],  live_q[8]};
  assign input_s3_config  = {live_q[15], live_q[14], live_q[13], live_q[12]};
  assign input_s4_config  = {live_q[19], live_q[18], live_q[17], live_q[16]};
  assign input_s5_config  = {live_q[23], live_q[22], live_q[21], live_q[20]};
  assign input_s6_config  = {live_q[27], live_q[26], live_q[25], live_q[24]};
  assign input_s7_config  = {live_q[31], live_q[30], live_q[29], live_q[28]};
  assign input_b_config   = live_q[32];
  assign input_ba_config  = live_q[33];
  assign input_acl_config = live_q[34];

endmodule

// File: tb/tb_input_config_loader.sv
// Randomised bench for input_config_loader: a byte-level reference model predicts
// every commit into a scoreboard queue that a negedge monitor drains and checks.
module tb_input_config_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        load_end;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        config_valid;
  logic        commit_pulse;
  logic        load_error;
  logic [31:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [7:0]  b_cfg, ba_cfg, acl_cfg;

  input_config_loader dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_end         (load_end),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .busy             (busy),
    .config_valid     (config_valid),
    .commit_pulse     (commit_pulse),
    .load_error       (load_error),
    .input_s0_config  (s0),
    .input_s1_config  (s1),
    .input_s2_config  (s2),
    .input_s3_config  (s3),
    .input_s4_config  (s4),
    .input_s5_config  (s5),
    .input_s6_config  (s6),
    .input_s7_config  (s7),
    .input_b_config   (b_cfg),
    .input_ba_config  (ba_cfg),
    .input_acl_config (acl_cfg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [7:0]   sh_m   [35];
  logic [7:0]   live_m [35];
  int           idx_m;
  bit           in_load_m, commit_m, err_m, cv_m, pulse_m;
  int           cyc;
  bit           mon_en;
  int           checks;
  int           errors;
  logic [279:0] exp_q[$];
  int           exp_cyc_q[$];

  // Order: s0..s7 (32 bits each) then b, ba, acl.
  function automatic logic [279:0] pack_model(input logic [7:0] a [35]);
    logic [279:0] r;
    logic [31:0]  w;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      w = 32'(a[4*k]) + (32'(a[4*k+1]) << 8) + (32'(a[4*k+2]) << 16) + (32'(a[4*k+3]) << 24);
      r[279-32*k -: 32] = w;
    end
    r[23:16] = a[32];
    r[15:8]  = a[33];
    r[7:0]   = a[34];
    return r;
  endfunction

  function automatic logic [279:0] pack_dut();
    return {s0, s1, s2, s3, s4, s5, s6, s7, b_cfg, ba_cfg, acl_cfg};
  endfunction

  task automatic check(input string name, input logic [279:0] act, input logic [279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit st, input bit en, input bit vl,
                       input logic [7:0] d);
    reset      = rst;
    load_start = st;
    load_end   = en;
    data_valid = vl;
    data_in    = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < 35; i++) begin
        sh_m[i]   = 8'h7F;
        live_m[i] = 8'h7F;
      end
      idx_m = 0; in_load_m = 0; commit_m = 0; err_m = 0; cv_m = 0; pulse_m = 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      pulse_m = 0;
      if (commit_m) begin
        live_m   = sh_m;
        cv_m     = 1;
        pulse_m  = 1;
        commit_m = 0;
      end else if (!in_load_m) begin
        if (st) begin
          in_load_m = 1; idx_m = 0; err_m = 0;
        end
      end else if (st) begin
        idx_m = 0; err_m = 0;
      end else begin
        if (vl) begin
          sh_m[idx_m] = d;
          idx_m++;
        end
        if (vl && idx_m == 35) begin
          in_load_m = 0;
          commit_m  = 1;
          exp_q.push_back(pack_model(sh_m));
          exp_cyc_q.push_back(cyc + 1);
        end else if (en) begin
          err_m     = 1;
          in_load_m = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'(($urandom)));
  endtask

  // mode 0: incrementing from 0, mode 1: constant fill, mode 2: random bytes
  task automatic send_bytes(input int n, input int mode, input logic [7:0] fill, input bit toggle);
    int sent;
    logic [7:0] d;
    sent = 0;
    while (sent < n) begin
      if (toggle && (cyc % 2 == 1)) begin
        drive(0, 0, 0, 0, 8'($urandom));
      end else begin
        d = (mode == 0) ? 8'(sent) : (mode == 1) ? fill : 8'($urandom);
        drive(0, 0, 0, 1, d);
        sent++;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("data_ready", 280'(data_ready), 280'(in_load_m));
      check("busy", 280'(busy), 280'(in_load_m | commit_m));
      check("load_error", 280'(load_error), 280'(err_m));
      check("config_valid", 280'(config_valid), 280'(cv_m));
      check("commit_pulse", 280'(commit_pulse), 280'(pulse_m));
      check("live_fields", pack_dut(), pack_model(live_m));
      if (commit_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected: got commit_pulse=1 expected no commit (cycle %0d)", cyc);
        end else begin
          check("commit_cfg", pack_dut(), exp_q.pop_front());
          check("commit_cycle", 280'(cyc), 280'(exp_cyc_q.pop_front()));
        end
      end else if (exp_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL commit_missing: got no commit_pulse expected one at cycle %0d (now %0d)",
                 exp_cyc_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit st, en, vl;
    checks = 0; errors = 0; cyc = 0; mon_en = 0;
    reset = 1; load_start = 0; load_end = 0; data_valid = 0; data_in = 0;

    drive(1, 0, 0, 0, 8'h00);
    mon_en = 1;
    drive(1, 0, 0, 1, 8'h55);
    idle(2);

    // Full incrementing stream, data_valid held high; load_end in IDLE is ignored.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(35, 0, 8'h00, 0);
    idle(3);
    check("s0_inc", 280'(s0), 280'(32'h03020100));
    check("s7_inc", 280'(s7), 280'(32'h1F1E1D1C));
    check("b_ba_acl_inc", 280'({b_cfg, ba_cfg, acl_cfg}), 280'(24'h202122));
    drive(0, 0, 1, 1, 8'h11);
    idle(2);

    // Same stream with data_valid toggling.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(35, 0, 8'h00, 1);
    idle(3);

    // Short stream ended by load_end after 10 bytes.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(10, 2, 8'h00, 0);
    drive(0, 0, 1, 0, 8'h00);
    idle(3);
    check("short_error", 280'(load_error), 280'(1));
    check("short_keeps_s0", 280'(s0), 280'(32'h03020100));

    // Restart after 20 bytes with a byte on the restart edge, then 35 x 8'h85.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(20, 2, 8'h00, 0);
    drive(0, 1, 0, 1, 8'hAA);
    send_bytes(35, 1, 8'h85, 0);
    idle(3);
    check("fill_s3", 280'(s3), 280'(32'h85858585));
    check("fill_acl", 280'(acl_cfg), 280'(8'h85));

    // load_end on the edge accepting the final byte still commits.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(34, 2, 8'h00, 0);
    drive(0, 0, 1, 1, 8'($urandom));
    idle(3);

    // start+end together: start wins; then a short end coinciding with a byte.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(5, 2, 8'h00, 0);
    drive(0, 1, 1, 0, 8'h00);
    send_bytes(3, 2, 8'h00, 0);
    drive(0, 0, 1, 1, 8'h42);
    idle(2);

    // Reset in the middle of a load, then data without load_start is ignored.
    drive(0, 1, 0, 0, 8'h00);
    send_bytes(17, 2, 8'h00, 0);
    drive(1, 0, 0, 1, 8'h99);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 8'($urandom));
    check("reset_s5", 280'(s5), 280'(32'h7F7F7F7F));
    check("reset_cv", 280'(config_valid), 280'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      st = 0; en = 0;
      vl = ($urandom_range(3, 0) != 0);
      if (!commit_m) begin
        if (!in_load_m) st = ($urandom_range(3, 0) == 0);
        else begin
          st = ($urandom_range(79, 0) == 0);
          en = ($urandom_range(119, 0) == 0);
        end
      end
      drive(0, st, en, vl, 8'($urandom));
    end
    idle(5);

    check("exp_q_drained", 280'(exp_q.size()), 280'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_config_loader.md
Name: input_config_loader

Overview:
- Loads the per-game input mapping (S0–S7 column words, plus the beta, BA and ACL bytes) from the byte stream the game-header loader produces.
- Presents the mapping as the live configuration fields consumed by the input mapping stage.
- Assembles bytes into a shadow buffer and commits atomically on the final byte, so the mapper never sees a partially loaded configuration.
- Sits between the data-slot/header parser and the system_config input fields.

Parameters:
- UNUSED_CODE, 8'h7F: per-input code meaning "input unused". It is the reset/fill value of every byte lane of every live field.
- CONFIG_BYTES, 35: stream length. 8 words × 4 bytes, then b, ba, acl. Fixed; not to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle pulse; begins (or restarts) a load
- load_end  in  1  upstream end-of-stream marker
- data_in  in  8  stream byte
- data_valid  in  1  data_in valid
- data_ready  out  1  loader accepts data_in this cycle
- busy  out  1  high in LOAD or COMMIT
- config_valid  out  1  a complete configuration has been committed since reset
- commit_pulse  out  1  one-cycle strobe when live fields update
- load_error  out  1  sticky; stream ended short
- input_s0_config … input_s7_config  out  32 each  live column config words
- input_b_config, input_ba_config, input_acl_config  out  8 each  live single-input codes

Behaviour:
- Reset values (synchronous, any state, including mid-load):
  - State IDLE; byte counter 0; data_ready, busy, config_valid, commit_pulse, load_error = 0.
  - All word outputs = {4{UNUSED_CODE}} = 32'h7F7F7F7F; byte outputs = 8'h7F; shadow filled likewise.
- States: IDLE, LOAD, COMMIT.
- IDLE:
  - data_ready = 0; data_valid is ignored.
  - load_start → LOAD: counter cleared, load_error cleared.
- LOAD:
  - data_ready = 1 combinationally; a byte is accepted on an edge where data_valid & data_ready.
  - Byte index i (0..34) = counter. Bytes 0..31 go to word i/4, lane i%4, little-endian (lane 0 → [7:0], lane 3 → [31:24]). Byte 32 → b, 33 → ba, 34 → acl.
  - Counter increments on accept. It is 6-bit and never wraps: leaving LOAD after index 34 bounds it.
  - Accepting index 34 → COMMIT.
- COMMIT (exactly one cycle):
  - data_ready = 0.
  - All live outputs load from the shadow on the exiting edge; config_valid ← 1; commit_pulse high for one cycle, coincident with the new live values; → IDLE.
- Latency: final byte accepted at edge N; live fields and commit_pulse change at edge N+1.
- Live outputs change only at commit or reset, never during LOAD.
- Short stream: load_end high in LOAD with fewer than 35 bytes accepted, counting a byte accepted on the same edge:
  - load_error ← 1; → IDLE; no commit.
  - Live fields and config_valid keep their prior values.
- load_end on the edge that accepts index 34: commit proceeds; no error.
- load_end in IDLE or COMMIT: ignored.
- load_start in LOAD:
  - Restarts: counter ← 0, load_error ← 0, stays in LOAD.
  - A byte presented on the same edge is discarded.
  - The shadow is not cleared; all 35 bytes must be re-sent.
- load_start in COMMIT: the commit completes; the start is honoured on the next edge only if still asserted. Upstream must not issue it then.
- load_start and load_end on the same edge: start wins; load_error is not set.
- load_error clears only on load_start or reset.
- busy = (state != IDLE).

Test Plan:
- Reset → all words 32'h7F7F7F7F, all bytes 8'h7F, config_valid = 0, data_ready = 0.
- load_start, then 35 bytes 8'h00..8'h22 with data_valid held high → s0 = 32'h03020100, s7 = 32'h1F1E1D1C, b = 8'h20, ba = 8'h21, acl = 8'h22. commit_pulse exactly one cycle after the byte-34 accept; config_valid = 1; live fields unchanged before that.
- Same stream with data_valid toggled every other cycle → identical result; counter advances only on valid cycles; data_ready stays high in LOAD.
- After a good commit, a new load ending with load_end after 10 bytes → load_error = 1, no commit_pulse, live fields still hold the first load, config_valid still 1.
- load_start after 20 bytes, then a full 35-byte stream of 8'h85 → all words 32'h85858585, single commit_pulse, load_error = 0.
- reset asserted at byte 17 of a load → all outputs return to reset values next edge; subsequent data_valid ignored until load_start.
